// File: rtl/fifo_flops_pkg.sv
// Shared defaults and pointer helper for the flop-based FIFO.
// Optional error flags are enabled by defining FIFO_FLOPS_ERR_EN.
package fifo_flops_pkg;

  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned DEFAULT_BITS  = 8;

  // Advance a circular-buffer index, wrapping depth-1 back to 0.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_flops_ptr.sv
// Wrapping index register for the flop FIFO; advances by one when inc is set.
module fifo_flops_ptr
  import fifo_flops_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = PW'(ptr_inc(32'(ptr_q), DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flops.sv
// Synchronous first-word-fall-through FIFO on a flop array.
// Define FIFO_FLOPS_ERR_EN to add sticky ovf/udf error outputs.
module fifo_flops
  import fifo_flops_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned BITS  = DEFAULT_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] Din,
  output logic [BITS-1:0] Dout,
  input  logic            push,
  input  logic            pop,
  output logic            full,
  output logic            pndng
`ifdef FIFO_FLOPS_ERR_EN
  ,
  output logic            ovf,
  output logic            udf
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            push_ok, pop_ok;

  assign pop_ok  = pop && (count_q != '0);
  // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
  assign push_ok = push && ((count_q < CW'(DEPTH)) || pop_ok);

  fifo_flops_ptr #(
    .DEPTH(DEPTH)
  ) u_wr_ptr (
    .clk(clk),
    .rst(rst),
    .inc(push_ok),
    .ptr(wr_ptr)
  );

  fifo_flops_ptr #(
    .DEPTH(DEPTH)
  ) u_rd_ptr (
    .clk(clk),
    .rst(rst),
    .inc(pop_ok),
    .ptr(rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr] <= Din;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign pndng = (count_q != '0);
  assign Dout  = pndng ? mem_q[rd_ptr] : '0;

`ifdef FIFO_FLOPS_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push && !push_ok) ovf_q <= 1'b1;
      if (pop && !pop_ok)   udf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_fifo_flops.sv
// Directed self-checking bench for fifo_flops at DEPTH=16, BITS=8.
module tb_fifo_flops;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] Din = '0;
  logic [7:0] Dout;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       full;
  logic       pndng;
`ifdef FIFO_FLOPS_ERR_EN
  logic       ovf;
  logic       udf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_flops #(
    .DEPTH(16),
    .BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Din(Din),
    .Dout(Dout),
    .push(push),
    .pop(pop),
    .full(full),
    .pndng(pndng)
`ifdef FIFO_FLOPS_ERR_EN
    ,
    .ovf(ovf),
    .udf(udf)
`endif
  );

  function automatic logic [7:0] fill_byte(input int i);
    return 8'((i * 37 + 5) & 8'hff);
  endfunction

  // One clock with the given request levels; outputs settle 1 ns after the edge.
  task automatic cyc(input logic p, input logic q, input logic [7:0] d);
    push = p;
    pop  = q;
    Din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL reset_pndng got=%b exp=0", pndng); end
    checks++; if (Dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", Dout); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, fill_byte(i));
      checks++;
      if (pndng !== 1'b1) begin failures++; $display("FAIL fill_pndng[%0d] got=%b exp=1", i, pndng); end
      checks++;
      if (Dout !== fill_byte(0)) begin
        failures++; $display("FAIL fill_dout[%0d] got=%h exp=%h", i, Dout, fill_byte(0));
      end
      checks++;
      if (full !== (i == 15)) begin
        failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 15));
      end
    end
  endtask

  task automatic test_overflow;
    cyc(1'b1, 1'b0, 8'hAA);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    checks++;
    if (Dout !== fill_byte(0)) begin
      failures++; $display("FAIL ovf_dout got=%h exp=%h", Dout, fill_byte(0));
    end
`ifdef FIFO_FLOPS_ERR_EN
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    checks++; if (udf !== 1'b0) begin failures++; $display("FAIL ovf_udf got=%b exp=0", udf); end
`endif
  endtask

  task automatic test_drain;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (Dout !== fill_byte(i)) begin
        failures++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, Dout, fill_byte(i));
      end
      cyc(1'b0, 1'b1, 8'h00);
    end
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL drain_pndng got=%b exp=0", pndng); end
    checks++; if (Dout !== 8'h00) begin failures++; $display("FAIL drain_dout_end got=%h exp=00", Dout); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL drain_full got=%b exp=0", full); end
  endtask

  task automatic test_wrap_simultaneous;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (Dout !== 8'(8'h40 + i)) begin
        failures++; $display("FAIL wrap_pop[%0d] got=%h exp=%h", i, Dout, 8'(8'h40 + i));
      end
      cyc(1'b0, 1'b1, 8'h00);
    end
    // Write pointer now wraps past 15 while filling these 12.
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
    checks++; if (Dout !== 8'h80) begin failures++; $display("FAIL wrap_head got=%h exp=80", Dout); end
    cyc(1'b1, 1'b1, 8'h5C);
    checks++; if (Dout !== 8'h81) begin failures++; $display("FAIL pp_dout got=%h exp=81", Dout); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL pp_full got=%b exp=0", full); end
    for (int i = 0; i < 12; i++) begin
      logic [7:0] exp_b;
      exp_b = (i < 11) ? 8'(8'h81 + i) : 8'h5C;
      checks++;
      if (Dout !== exp_b) begin
        failures++; $display("FAIL pp_drain[%0d] got=%h exp=%h", i, Dout, exp_b);
      end
      cyc(1'b0, 1'b1, 8'h00);
    end
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL pp_empty got=%b exp=0", pndng); end
  endtask

  task automatic test_underflow_reset;
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL udf_pndng got=%b exp=0", pndng); end
    checks++; if (Dout !== 8'h00) begin failures++; $display("FAIL udf_dout got=%h exp=00", Dout); end
`ifdef FIFO_FLOPS_ERR_EN
    checks++; if (udf !== 1'b1) begin failures++; $display("FAIL udf_flag got=%b exp=1", udf); end
`endif
    // Push+pop on empty is a plain push.
    cyc(1'b1, 1'b1, 8'h33);
    checks++; if (pndng !== 1'b1) begin failures++; $display("FAIL epp_pndng got=%b exp=1", pndng); end
    checks++; if (Dout !== 8'h33) begin failures++; $display("FAIL epp_dout got=%h exp=33", Dout); end
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL epp_pop got=%b exp=0", pndng); end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
    checks++; if (Dout !== 8'hC0) begin failures++; $display("FAIL mid_head got=%h exp=c0", Dout); end
    rst = 1'b1;
    cyc(1'b1, 1'b0, 8'hEE);
    rst = 1'b0;
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL mid_pndng got=%b exp=0", pndng); end
    checks++; if (Dout !== 8'h00) begin failures++; $display("FAIL mid_dout got=%h exp=00", Dout); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL mid_full got=%b exp=0", full); end
`ifdef FIFO_FLOPS_ERR_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL mid_ovf got=%b exp=0", ovf); end
    checks++; if (udf !== 1'b0) begin failures++; $display("FAIL mid_udf got=%b exp=0", udf); end
`endif
    cyc(1'b1, 1'b0, 8'h9D);
    checks++; if (Dout !== 8'h9D) begin failures++; $display("FAIL post_rst_dout got=%h exp=9d", Dout); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap_simultaneous();
    test_underflow_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
